// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch. Owns the PC, addresses a combinational
// instruction memory and holds the fetched word in an IF/ID register towards decode.
//
// Parameters:
//   N         datapath / address width
//   RESET_PC  first byte address fetched after reset (4-byte aligned)
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   imem_addr        word index into instruction memory (pc >> 2)
//   imem_rd          instruction word, combinational return for imem_addr
//   redirect_valid   taken branch/jump: flush and load redirect_pc
//   redirect_pc      byte target of the redirect
//   halt_req         stop fetching
//   resume           leave HALTED, continue at the current pc
//   id_ready         decode accepts id_* this cycle
//   id_valid         id_* carries a valid instruction
//   id_instr         fetched instruction
//   id_pc            byte address of id_instr
//   id_pc_plus4      id_pc + 4 (link value)
//   halted           high while in HALTED
// Optional build macro FETCH_MISALIGN_TRAP_EN adds:
//   misalign         sticky flag: a redirect targeted a non-word-aligned address
//   misalign_addr    the offending redirect target
// Without the macro the low two target bits are dropped on redirect.

module fetch_stage #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_rd,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    input  logic         halt_req,
    input  logic         resume,
    input  logic         id_ready,
    output logic         id_valid,
    output logic [N-1:0] id_instr,
    output logic [N-1:0] id_pc,
    output logic [N-1:0] id_pc_plus4,
    output logic         halted
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic         misalign,
    output logic [N-1:0] misalign_addr
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] target;
    logic         stall;
    logic         bad_target;

    // Decode holds an entry it has not accepted yet.
    assign stall    = id_valid && !id_ready;
    assign pc_plus4 = pc + N'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign target     = redirect_pc;
`else
    assign bad_target = 1'b0;
    // Low two bits of the target are forced to zero.
    assign target     = redirect_pc & ~N'(3);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (redirect_valid) begin
                    state_nxt = bad_target ? HALTED : RUN;
                end else if (halt_req) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (bad_target) begin
                    state_nxt = HALTED;
                end else if (resume) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Outputs derived from state and pc
    always_comb begin
        halted    = (state == HALTED);
        imem_addr = pc >> 2;
    end

    // PC and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            // Flush, including an entry decode is stalling on.
            if (!bad_target) begin
                pc <= target;
            end
            id_valid <= 1'b0;
        end else if (state == HALTED) begin
            // No fetch; a pending entry drains on handshake.
            if (id_valid && id_ready) begin
                id_valid <= 1'b0;
            end
        end else if (halt_req) begin
            if (!stall) begin
                id_valid <= 1'b0;
            end
        end else if (!stall) begin
            id_instr    <= imem_rd;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            pc          <= pc_plus4;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else if (bad_target) begin
            misalign      <= 1'b1;
            misalign_addr <= redirect_pc;
        end else if (resume) begin
            misalign      <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic for fetch_stage,
// checked against a behavioural model of the fetch rules.

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    logic [31:0] mem [64];
    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_v;
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic        m_mis;
    logic [31:0] m_maddr;

    always #5 clk = ~clk;

    assign imem_rd = mem[imem_addr[5:0]];

    fetch_stage #(.N(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume         (resume),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .halted         (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign       (misalign),
        .misalign_addr  (misalign_addr)
`endif
    );

    // Advance the model by one clock using the current inputs, then the DUT.
    task automatic tick();
        logic [31:0] word;
        logic        trap;
        word = mem[m_pc[7:2]];
        trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
        if (rst) begin
            m_pc = RESET_PC; m_halt = 0; m_v = 0;
            m_instr = 0; m_idpc = 0; m_idpc4 = 0;
            m_mis = 0; m_maddr = 0;
        end else if (trap) begin
            m_v = 0; m_halt = 1; m_mis = 1; m_maddr = redirect_pc;
        end else if (!m_halt) begin
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00}; m_v = 0;
            end else if (halt_req) begin
                m_halt = 1;
                if (!(m_v && !id_ready)) m_v = 0;
            end else if (!(m_v && !id_ready)) begin
                m_instr = word; m_idpc = m_pc; m_idpc4 = m_pc + 4;
                m_v = 1; m_pc = m_pc + 4;
            end
        end else begin
            if (m_v && id_ready) m_v = 0;
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00}; m_v = 0;
            end
            if (resume) begin
                m_halt = 0; m_mis = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; redirect_valid = 0; redirect_pc = 0;
        halt_req = 0; resume = 0; id_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b exp 0", id_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
        checks++; if (imem_addr !== (RESET_PC >> 2)) begin errors++; $display("FAIL reset_imem_addr got %h exp %h", imem_addr, RESET_PC >> 2); end
        checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_id_instr got %h exp 0", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
        checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_id_pc_plus4 got %h exp 0", id_pc_plus4); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_addr !== 32'(k)) begin errors++; $display("FAIL seq_imem_addr got %h exp %h", imem_addr, k); end
            tick();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_id_valid got %0b exp 1", id_valid); end
            checks++; if (id_pc !== 32'(4 * k)) begin errors++; $display("FAIL seq_id_pc got %h exp %h", id_pc, 4 * k); end
            checks++; if (id_instr !== mem[k]) begin errors++; $display("FAIL seq_id_instr got %h exp %h", id_instr, mem[k]); end
            checks++; if (id_pc_plus4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL seq_id_pc_plus4 got %h exp %h", id_pc_plus4, 4 * k + 4); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(); tick(); tick();
        id_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL stall_id_pc got %h exp 8", id_pc); end
            checks++; if (id_instr !== mem[2]) begin errors++; $display("FAIL stall_id_instr got %h exp %h", id_instr, mem[2]); end
            checks++; if (imem_addr !== 32'h3) begin errors++; $display("FAIL stall_imem_addr got %h exp 3", imem_addr); end
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_id_valid got %0b exp 1", id_valid); end
        end
        id_ready = 1;
        tick();
        checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL stall_release_pc got %h exp c", id_pc); end
        checks++; if (id_instr !== mem[3]) begin errors++; $display("FAIL stall_release_instr got %h exp %h", id_instr, mem[3]); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        tick(); tick(); tick();
        id_ready = 0;
        tick();
        redirect_valid = 1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %0b exp 0", id_valid); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL redir_imem_addr got %h exp 10", imem_addr); end
        tick();
        checks++; if (id_pc !== 32'h40 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_target got pc=%h v=%0b exp pc=40 v=1", id_pc, id_valid); end
        checks++; if (id_instr !== mem[16]) begin errors++; $display("FAIL redir_instr got %h exp %h", id_instr, mem[16]); end
        id_ready = 1;
    endtask

    task automatic test_halt_resume();
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        id_ready = 0; halt_req = 1;
        tick();
        halt_req = 0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0b exp 1", halted); end
        checks++; if (imem_addr !== 32'h5) begin errors++; $display("FAIL halt_imem_addr got %h exp 5", imem_addr); end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10) begin errors++; $display("FAIL halt_pending got v=%0b pc=%h exp v=1 pc=10", id_valid, id_pc); end
        tick();
        id_ready = 1;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got %0b exp 0", id_valid); end
        checks++; if (imem_addr !== 32'h5 || halted !== 1'b1) begin errors++; $display("FAIL halt_frozen got addr=%h h=%0b exp addr=5 h=1", imem_addr, halted); end
        resume = 1;
        tick();
        resume = 0;
        checks++; if (halted !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL resume_state got h=%0b v=%0b exp h=0 v=0", halted, id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14) begin errors++; $display("FAIL resume_fetch got v=%0b pc=%h exp v=1 pc=14", id_valid, id_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(); tick();
        id_ready = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL midrst_id_valid got %0b exp 0", id_valid); end
        checks++; if (imem_addr !== (RESET_PC >> 2)) begin errors++; $display("FAIL midrst_imem_addr got %h exp %h", imem_addr, RESET_PC >> 2); end
        id_ready = 1; halt_req = 1;
        tick();
        halt_req = 0; rst = 1;
        tick();
        rst = 0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL midrst_halted got %0b exp 0", halted); end
    endtask

    task automatic test_misaligned_redirect();
        do_reset();
        tick();
        redirect_valid = 1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1 || misalign_addr !== 32'h42) begin errors++; $display("FAIL mis_flag got %0b/%h exp 1/42", misalign, misalign_addr); end
        checks++; if (halted !== 1'b1 || imem_addr !== 32'h1) begin errors++; $display("FAIL mis_halt got h=%0b addr=%h exp h=1 addr=1", halted, imem_addr); end
        resume = 1;
        tick();
        resume = 0;
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %0b exp 0", misalign); end
`else
        checks++; if (imem_addr !== 32'h10 || halted !== 1'b0) begin errors++; $display("FAIL mis_ignore got addr=%h h=%0b exp addr=10 h=0", imem_addr, halted); end
        tick();
        checks++; if (id_pc !== 32'h40 || id_pc_plus4 !== 32'h44) begin errors++; $display("FAIL mis_target got %h/%h exp 40/44", id_pc, id_pc_plus4); end
`endif
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        tick();
        checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_link got %h/%h exp fffffffc/0", id_pc, id_pc_plus4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", imem_addr); end
        checks++; if (id_instr !== mem[63]) begin errors++; $display("FAIL wrap_instr got %h exp %h", id_instr, mem[63]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst            = ($urandom_range(0, 79) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            halt_req       = ($urandom_range(0, 15) == 0);
            resume         = ($urandom_range(0, 3) == 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            tick();
            checks++; if (imem_addr !== (m_pc >> 2)) begin errors++; $display("FAIL rnd_imem_addr cyc %0d got %h exp %h", n, imem_addr, m_pc >> 2); end
            checks++; if (id_valid !== m_v) begin errors++; $display("FAIL rnd_id_valid cyc %0d got %0b exp %0b", n, id_valid, m_v); end
            checks++; if (halted !== m_halt) begin errors++; $display("FAIL rnd_halted cyc %0d got %0b exp %0b", n, halted, m_halt); end
            checks++; if (id_instr !== m_instr) begin errors++; $display("FAIL rnd_id_instr cyc %0d got %h exp %h", n, id_instr, m_instr); end
            checks++; if (id_pc !== m_idpc) begin errors++; $display("FAIL rnd_id_pc cyc %0d got %h exp %h", n, id_pc, m_idpc); end
            checks++; if (id_pc_plus4 !== m_idpc4) begin errors++; $display("FAIL rnd_id_pc_plus4 cyc %0d got %h exp %h", n, id_pc_plus4, m_idpc4); end
`ifdef FETCH_MISALIGN_TRAP_EN
            checks++; if (misalign !== m_mis || (m_mis && misalign_addr !== m_maddr)) begin errors++; $display("FAIL rnd_misalign cyc %0d got %0b/%h exp %0b/%h", n, misalign, misalign_addr, m_mis, m_maddr); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        m_pc = RESET_PC; m_halt = 0; m_v = 0;
        m_instr = 0; m_idpc = 0; m_idpc4 = 0;
        m_mis = 0; m_maddr = 0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt_resume();
        test_reset_mid();
        test_misaligned_redirect();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
